// File: rtl/lc3_memaccess_ctrl.sv
// lc3_memaccess_ctrl: LC3 memory-access sequencer with pointer fetch for LDI/STI, wait states and timeout
module lc3_memaccess_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mem_state,
  input  logic              M_Control,
  input  logic [ADDR_W-1:0] M_Addr,
  input  logic [DATA_W-1:0] M_Data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] memout,
  output logic              err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic [DATA_W-1:0] dmem_dout,
  input  logic              dmem_ack
);
  typedef enum logic [1:0] {IDLE, PTR, ACC, RESP} state_t;
  state_t     state;
  logic       wr;
  logic [7:0] cnt;
  logic       tmo;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  // dmem_addr doubles as the pointer register once the PTR fetch completes
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      memout    <= '0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      dmem_addr <= '0;
      dmem_din  <= '0;
      wr        <= 1'b0;
      cnt       <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          err       <= 1'b0;
          wr        <= mem_state == 2'd2;
          dmem_addr <= M_Addr;
          dmem_din  <= M_Data;
          cnt       <= '0;
          if (mem_state == 2'd3) begin
            done  <= 1'b1;
            state <= RESP;
          end else begin
            dmem_req <= 1'b1;
            dmem_we  <= mem_state == 2'd2 && !M_Control;
            state    <= (mem_state == 2'd1 || (mem_state == 2'd2 && M_Control)) ? PTR : ACC;
          end
        end
        PTR, ACC: if (dmem_ack) begin
          if (state == PTR) begin
            dmem_addr <= ADDR_W'(dmem_dout);
            dmem_we   <= wr;
            cnt       <= '0;
            state     <= ACC;
          end else begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            done     <= 1'b1;
            state    <= RESP;
            if (!wr) memout <= dmem_dout;
          end
        end else if (tmo) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          err      <= 1'b1;
          done     <= 1'b1;
          state    <= RESP;
        end else
          cnt <= cnt + 8'd1;
        RESP: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// tb_lc3_memaccess_ctrl: randomized and directed checks of lc3_memaccess_ctrl against a memory-level model
module tb_lc3_memaccess_ctrl;
  logic        clk = 0, rst_n = 0, start = 0, M_Control = 0;
  logic [1:0]  mem_state = 0;
  logic [15:0] M_Addr = 0, M_Data = 0, dmem_dout = 0;
  logic        dmem_ack = 0;
  logic        busy, done, err, dmem_req, dmem_we;
  logic [15:0] memout, dmem_addr, dmem_din;

  lc3_memaccess_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
    .clock(clk), .reset(rst_n), .start(start), .mem_state(mem_state), .M_Control(M_Control),
    .M_Addr(M_Addr), .M_Data(M_Data), .busy(busy), .done(done), .memout(memout), .err(err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; logic we; logic [15:0] d; } req_t;
  req_t        log[$];
  req_t        cur;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] m_memout = 0;
  int wait_cfg = 0, wcnt = 0, req_cycles = 0, stab_bad = 0;
  bit no_ack = 0;
  int n_cmp = 0, n_bad = 0;

  // memory with a programmable number of wait states per request
  always @(negedge clk) begin
    if (dmem_req) begin
      if (wcnt == 0) begin
        cur = '{dmem_addr, dmem_we, dmem_din};
        log.push_back(cur);
      end else if (cur.a !== dmem_addr || cur.we !== dmem_we || cur.d !== dmem_din)
        stab_bad++;
      req_cycles++;
      if (!no_ack && wcnt == wait_cfg) begin
        dmem_ack  = 1;
        dmem_dout = mem[dmem_addr];
        if (dmem_we) mem[dmem_addr] = dmem_din;
        wcnt = 0;
      end else begin
        dmem_ack = 0;
        wcnt++;
      end
    end else begin
      dmem_ack  = ($urandom_range(3) == 0);
      dmem_dout = 16'($urandom);
      wcnt      = 0;
    end
  end

  task automatic test_reset;
    @(posedge clk); #1;
    n_cmp++; if ({busy, done, err, dmem_req, dmem_we} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, dmem_req, dmem_we}); end
    n_cmp++; if ({memout, dmem_addr, dmem_din} !== 48'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {memout, dmem_addr, dmem_din}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_access(input logic [1:0] ms, input logic ctl, input logic [15:0] a, d, input int w, input string nm);
    req_t e[$];
    int lat;
    logic [15:0] p;
    bit wrt;
    wrt = ms == 2;
    if (ms != 3) begin
      p = a;
      if (ms == 1 || (ms == 2 && ctl)) begin
        e.push_back('{a, 1'b0, 16'h0});
        p = ref_mem[a];
      end
      e.push_back('{p, wrt, d});
      if (wrt) ref_mem[p] = d; else m_memout = ref_mem[p];
    end
    wait_cfg = w;
    log.delete();
    @(negedge clk); start = 1; mem_state = ms; M_Control = ctl; M_Addr = a; M_Data = d;
    @(negedge clk); start = 0; mem_state = 2'($urandom); M_Control = 1'($urandom); M_Addr = 16'($urandom); M_Data = 16'($urandom);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_after_start: got %b want 1", nm, busy); end
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 1 + e.size() * (1 + w)) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, lat, 1 + e.size() * (1 + w)); end
    n_cmp++; if (memout !== m_memout) begin n_bad++; $display("FAIL %s memout: got %h want %h", nm, memout, m_memout); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s err: got %b want 0", nm, err); end
    n_cmp++; if (log.size() !== e.size()) begin n_bad++; $display("FAIL %s req_count: got %0d want %0d", nm, log.size(), e.size()); end
    for (int i = 0; i < e.size() && i < log.size(); i++) begin
      n_cmp++;
      if (log[i].a !== e[i].a || log[i].we !== e[i].we || (e[i].we && log[i].d !== e[i].d)) begin
        n_bad++; $display("FAIL %s req%0d: got a=%h we=%b d=%h want a=%h we=%b d=%h", nm, i, log[i].a, log[i].we, log[i].d, e[i].a, e[i].we, e[i].d);
      end
    end
    n_cmp++; if (stab_bad !== 0) begin n_bad++; $display("FAIL %s req_stable: got %0d changes want 0", nm, stab_bad); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL %s after_done: got busy,done=%b want 00", nm, {busy, done}); end
  endtask

  task automatic test_directed;
    mem[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
    test_access(0, 0, 16'h3000, 16'($urandom), 0, "ld_zero_wait");
    mem[16'h3001] = 16'h4000; ref_mem[16'h3001] = 16'h4000;
    mem[16'h4000] = 16'hBEEF; ref_mem[16'h4000] = 16'hBEEF;
    test_access(1, 0, 16'h3001, 16'h0, 2, "ldi_two_wait");
    mem[16'h3002] = 16'h5000; ref_mem[16'h3002] = 16'h5000;
    test_access(2, 1, 16'h3002, 16'hA5A5, 0, "sti");
    test_access(2, 0, 16'h3100, 16'h5A5A, 1, "st_one_wait");
    test_access(0, 0, 16'h3100, 16'h0, 3, "ld_back_st");
    test_access(3, 0, 16'h1111, 16'h2222, 0, "idle_op");
  endtask

  task automatic test_timeout;
    int lat;
    no_ack = 1; req_cycles = 0; log.delete();
    @(negedge clk); start = 1; mem_state = 0; M_Control = 0; M_Addr = 16'($urandom);
    @(negedge clk); start = 0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL tmo latency: got %0d want 5", lat); end
    n_cmp++; if (req_cycles !== 4) begin n_bad++; $display("FAIL tmo req_cycles: got %0d want 4", req_cycles); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo err: got %b want 1", err); end
    n_cmp++; if (memout !== m_memout) begin n_bad++; $display("FAIL tmo memout: got %h want %h", memout, m_memout); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL tmo req_dropped: got %b want 0", dmem_req); end
    no_ack = 0;
    test_access(3, 0, 16'h0, 16'h0, 0, "idle_clears_err");
  endtask

  task automatic test_reset_mid;
    no_ack = 1;
    @(negedge clk); start = 1; mem_state = 0; M_Control = 0; M_Addr = 16'($urandom);
    @(negedge clk); start = 0;
    @(negedge clk); #2 rst_n = 0; #1;
    n_cmp++; if ({dmem_req, busy, done} !== 3'b000) begin n_bad++; $display("FAIL rst_mid flags: got req,busy,done=%b want 000", {dmem_req, busy, done}); end
    n_cmp++; if (memout !== 16'h0) begin n_bad++; $display("FAIL rst_mid memout: got %h want 0000", memout); end
    @(negedge clk); rst_n = 1; no_ack = 0; m_memout = 0;
    test_access(0, 0, 16'($urandom), 16'h0, 1, "ld_after_rst");
  endtask

  task automatic test_busy_start;
    int nd = 0, lat = 0;
    bit seen = 0;
    logic [15:0] a;
    a = 16'($urandom);
    m_memout = ref_mem[a]; wait_cfg = 3; log.delete();
    @(negedge clk); start = 1; mem_state = 0; M_Control = 0; M_Addr = a;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); mem_state = 3; start = !seen;
      if (done === 1'b1) begin nd++; if (!seen) lat = k; seen = 1; end
    end
    start = 0;
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL busy_start done_count: got %0d want 1", nd); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL busy_start latency: got %0d want 5", lat); end
    n_cmp++; if (memout !== m_memout) begin n_bad++; $display("FAIL busy_start memout: got %h want %h", memout, m_memout); end
    n_cmp++; if (log.size() !== 1) begin n_bad++; $display("FAIL busy_start req_count: got %0d want 1", log.size()); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      test_access(2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(3), $sformatf("rand%0d", i));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = 16'($urandom); ref_mem[i] = mem[i]; end
    test_reset;
    test_directed;
    test_timeout;
    test_reset_mid;
    test_busy_start;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lc3_memaccess_ctrl.md
Name: lc3_memaccess_ctrl

Overview:
Cycle-accurate LC3 memory-access sequencer that consumes the memaccess_in signal set: M_Addr, M_Data, M_Control, mem_state.
Drives the data-memory port through a req/ack handshake with wait states.
Resolves indirect accesses (LDI/STI) by fetching a pointer first.
Returns the load result to writeback on memout with a one-cycle done pulse.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, memory address width
TIMEOUT, 255, max cycles a request may wait for ack before abort (1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin an access; inputs sampled this cycle
mem_state  in  2  0=read, 1=read indirect (LDI), 2=write, 3=idle/no-op
M_Control  in  1  for mem_state=2: 0=ST/STR direct, 1=STI indirect; ignored otherwise
M_Addr  in  ADDR_W  effective address (or pointer address when indirect)
M_Data  in  DATA_W  store data
busy  out  1  high from cycle after start until done cycle inclusive
done  out  1  one-cycle completion pulse
memout  out  DATA_W  load result; valid with done, held until next load completes
err  out  1  timeout flag; set with done, cleared at next accepted start
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1=write, valid with dmem_req
dmem_addr  out  ADDR_W  memory address, valid with dmem_req
dmem_din  out  DATA_W  write data, valid with dmem_req
dmem_dout  in  DATA_W  read data, valid when dmem_ack high
dmem_ack  in  1  memory completes current request; honoured only while dmem_req high

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, err, dmem_req, dmem_we = 0; memout, dmem_addr, dmem_din, pointer reg, timeout counter = 0. Outputs drop immediately, including mid-transaction; the pending access is abandoned.
- States: IDLE, PTR, ACC, RESP.
- IDLE:
  - start=1 and busy=0: latch mem_state, M_Control, M_Addr, M_Data; clear err.
  - mem_state 1, or mem_state 2 with M_Control=1: go to PTR.
  - mem_state 0, or mem_state 2 with M_Control=0: go to ACC.
  - mem_state 3: go to RESP with no memory request.
- PTR: dmem_req=1, dmem_we=0, dmem_addr=latched M_Addr. On dmem_ack, latch dmem_dout into pointer reg and go to ACC.
- ACC: dmem_req=1; dmem_addr = pointer (indirect) or latched M_Addr (direct).
  - Read: dmem_we=0; on ack, latch dmem_dout into memout.
  - Write: dmem_we=1, dmem_din = latched M_Data; memout unchanged.
  - On ack, go to RESP.
- RESP: done=1 for exactly one cycle, then IDLE. busy=0 the following cycle.
- All outputs are registered.
- dmem_req rises the cycle after the state is entered and stays high, with stable addr/we/din, until the cycle dmem_ack is sampled high.
- Back-to-back requests: PTR ack → ACC keeps req high for the next address; a new address appears in the cycle after the ack.
- Latency, zero-wait memory (ack in first req cycle):
  - Direct: start@T, req@T+1, done@T+2.
  - Indirect: done@T+3.
  - Idle: done@T+1.
  - Each wait cycle adds 1.
- Timeout: an 8-bit counter resets on each new request and increments each req cycle without ack. On reaching TIMEOUT: drop req, set err=1, go to RESP (done pulses), memout unchanged.
- start while busy=1: ignored, no effect.
- start in the same cycle as done: ignored; must wait for busy=0.
- dmem_ack while dmem_req=0: ignored.

Test Plan:
- Direct read, zero wait: M_Addr=0x3000, mem holds 0x1234 -> req@T+1 addr=0x3000 we=0, done@T+2, memout=0x1234, err=0.
- LDI with 2 wait states per access: mem[0x3001]=0x4000, mem[0x4000]=0xBEEF -> req addrs 0x3001 then 0x4000; memout=0xBEEF; done@T+7.
- STI: M_Control=1, M_Addr=0x3002, mem[0x3002]=0x5000, M_Data=0xA5A5 -> write req addr=0x5000 din=0xA5A5 we=1; memout keeps previous 0xBEEF.
- Timeout with TIMEOUT=4, ack never asserted -> req high 4 cycles then low, done with err=1. The next start clears err.
- Reset asserted while in ACC waiting for ack -> dmem_req, busy, done = 0 immediately, state IDLE. After release, a fresh direct read completes normally.
- start during busy and mem_state=3 -> extra start ignored (single done); mem_state=3 start gives done@T+1 with no dmem_req.
